// File: rtl/esm_issue_buffer_pkg.sv
// Shared sizing defaults and types for the issue buffer slice.
package esm_pkg;

  localparam int ESM_IW          = 32;
  localparam int ESM_BS          = 16;
  localparam int ESM_ISSUE_DELAY = 2;

  localparam int BS_BITS = $clog2(ESM_BS);

  typedef logic [BS_BITS-1:0] slot_idx_t;
  typedef logic [ESM_IW-1:0]  instr_word_t;

  // A zero delay still needs a one-bit counter to keep the vectors legal.
  function automatic int age_width(input int delay);
    return (delay > 0) ? $clog2(delay + 1) : 1;
  endfunction

  localparam int AGE_W = age_width(ESM_ISSUE_DELAY);

endpackage

// File: rtl/esm_issue_buffer_if.sv
// Fetch, IDA and execute-side signals of the issue buffer; slave = buffer side.
interface esm_issue_buffer_if
  import esm_pkg::*;
#(
  parameter int bs = ESM_BS,
  parameter int iw = ESM_IW
);
  localparam int BW = $clog2(bs);

  logic          in_valid;
  logic          in_ready;
  logic [iw-1:0] Instr_in;
  logic          alloc_fire;
  logic [BW-1:0] buffer_index;
  logic [0:bs-1] valid_entries;
  logic [0:bs-1] independent_instr;
  logic          issue_valid;
  logic          issue_ready;
  logic [iw-1:0] issue_instr;
  logic [BW-1:0] issue_index;

  modport slave (
    input  in_valid, Instr_in, independent_instr, issue_ready,
    output in_ready, alloc_fire, buffer_index, valid_entries,
           issue_valid, issue_instr, issue_index
  );

  modport master (
    output in_valid, Instr_in, independent_instr, issue_ready,
    input  in_ready, alloc_fire, buffer_index, valid_entries,
           issue_valid, issue_instr, issue_index
  );

endinterface

// File: rtl/esm_issue_buffer_rr_arbiter.sv
// Combinational round-robin picker: first request at or after start, wrapping.
module esm_rr_arbiter
  import esm_pkg::*;
#(
  parameter int bs = ESM_BS
) (
  input  logic [0:bs-1]         request,
  input  logic [$clog2(bs)-1:0] start,
  output logic                  grant_valid,
  output logic [$clog2(bs)-1:0] grant_index
);
  localparam int BW = $clog2(bs);

  logic [0:bs-1] rotated;
  logic [BW-1:0] offset;

  // rotated[k] is the request k positions after start; bs is a power of two so the sum wraps.
  generate
    for (genvar gi = 0; gi < bs; gi++) begin : g_rot
      assign rotated[gi] = request[BW'(start + BW'(gi))];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (rotated[i]) offset = BW'(i);
    end
  end

  assign grant_valid = |rotated;
  assign grant_index = BW'(start + offset);

endmodule

// File: rtl/esm_issue_buffer.sv
// Instruction holding buffer between fetch, the IDA dependency core and execute.
// Optional perf counters are enabled by defining ESM_ISSUE_PERF_EN.
module esm_issue_buffer
  import esm_pkg::*;
#(
  parameter int Instruction_word_size = ESM_IW,
  parameter int bs                    = ESM_BS,
  parameter int ISSUE_DELAY           = ESM_ISSUE_DELAY
) (
  input  logic clk,
  input  logic rst,
  esm_issue_buffer_if.slave bus
`ifdef ESM_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_full
`endif
);
  localparam int BW = $clog2(bs);
  localparam int AW = age_width(ISSUE_DELAY);

  logic                             slot_valid_reg [bs];
  logic [AW-1:0]                    age_reg [bs];
  logic [Instruction_word_size-1:0] mem [bs];

  logic [0:bs-1] valid_vec;
  logic [0:bs-1] free;
  logic [0:bs-1] matured;
  logic [0:bs-1] held;
  logic [0:bs-1] eligible;

  logic [BW-1:0] alloc_index;
  logic          alloc_fire;
  logic [BW-1:0] rr_reg;
  logic [BW-1:0] arb_start;
  logic          grant_valid;
  logic [BW-1:0] grant_index;

  logic                             issue_valid_reg;
  logic [BW-1:0]                    issue_index_reg;
  logic [Instruction_word_size-1:0] issue_instr_reg;
  logic                             issue_fire;
  logic                             issue_load;

  assign free       = ~valid_vec;
  assign alloc_fire = bus.in_valid & (|free);

  // Lowest-numbered free slot; slot 0 is the MSB of the [0:bs-1] vectors.
  always_comb begin
    alloc_index = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (free[i]) alloc_index = BW'(i);
    end
  end

  assign issue_fire = issue_valid_reg & bus.issue_ready;
  assign issue_load = ~issue_valid_reg | issue_fire;

  generate
    for (genvar gi = 0; gi < bs; gi++) begin : g_slot
      assign valid_vec[gi] = slot_valid_reg[gi];
      assign matured[gi]   = slot_valid_reg[gi] & (age_reg[gi] == '0);
      assign held[gi]      = issue_valid_reg & (issue_index_reg == BW'(gi));

      // A slot being issued is matured and occupied, so it is never the allocation target.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_valid_reg[gi] <= 1'b0;
          age_reg[gi]        <= '0;
        end else if (alloc_fire && (alloc_index == BW'(gi))) begin
          slot_valid_reg[gi] <= 1'b1;
          age_reg[gi]        <= AW'(ISSUE_DELAY);
        end else begin
          if (issue_fire && (issue_index_reg == BW'(gi))) slot_valid_reg[gi] <= 1'b0;
          if (slot_valid_reg[gi] && (age_reg[gi] != '0)) age_reg[gi] <= age_reg[gi] - 1'b1;
        end
      end
    end
  endgenerate

  assign eligible = matured & bus.independent_instr & ~held;

  // On a handshake the next winner is searched from just past the departing slot.
  assign arb_start = issue_fire ? BW'(issue_index_reg + 1'b1) : rr_reg;

  esm_rr_arbiter #(.bs(bs)) u_arb (
    .request     (eligible),
    .start       (arb_start),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  always_ff @(posedge clk) begin
    if (alloc_fire) mem[alloc_index] <= bus.Instr_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_reg <= 1'b0;
      issue_index_reg <= '0;
      issue_instr_reg <= '0;
      rr_reg          <= '0;
    end else begin
      if (issue_fire) rr_reg <= BW'(issue_index_reg + 1'b1);
      if (issue_load) begin
        issue_valid_reg <= grant_valid;
        if (grant_valid) begin
          issue_index_reg <= grant_index;
          issue_instr_reg <= mem[grant_index];
        end
      end
    end
  end

  assign bus.in_ready      = |free;
  assign bus.alloc_fire    = alloc_fire;
  assign bus.buffer_index  = alloc_index;
  assign bus.valid_entries = valid_vec;
  assign bus.issue_valid   = issue_valid_reg;
  assign bus.issue_index   = issue_index_reg;
  assign bus.issue_instr   = issue_instr_reg;

`ifdef ESM_ISSUE_PERF_EN
  logic [31:0] issued_reg;
  logic [31:0] stall_reg;
  logic [31:0] full_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_reg <= '0;
      stall_reg  <= '0;
      full_reg   <= '0;
    end else begin
      if (issue_fire && (issued_reg != '1)) issued_reg <= issued_reg + 1'b1;
      if (issue_valid_reg && !bus.issue_ready && (stall_reg != '1)) stall_reg <= stall_reg + 1'b1;
      if (bus.in_valid && !(|free) && (full_reg != '1)) full_reg <= full_reg + 1'b1;
    end
  end

  assign perf_issued = issued_reg;
  assign perf_stall  = stall_reg;
  assign perf_full   = full_reg;
`endif

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer with a slot/timestamp reference model checked every cycle.
module tb_esm_issue_buffer;
  localparam int BS = 16;
  localparam int D  = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  esm_issue_buffer_if #(.bs(BS), .iw(32)) bus ();

`ifdef ESM_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_full;
`endif

  esm_issue_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ESM_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
    .perf_full   (perf_full)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: occupancy flags, allocation timestamps, presented slot and rr pointer.
  bit          m_valid [BS];
  int          m_acyc  [BS];
  logic [31:0] m_data  [BS];
  bit          m_iv;
  int          m_idx;
  int          m_rr;
  logic [31:0] m_instr;
  int          cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int  lo, start, win;
    bit  full, found, do_alloc, hs;
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < BS; i++) m_valid[i] = 0;
        m_iv = 0; m_idx = 0; m_rr = 0;
      end else begin
        full = 1; lo = 0;
        for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) begin full = 0; lo = i; end
        do_alloc = bus.in_valid && !full;
        hs = m_iv && bus.issue_ready;
        start = hs ? (m_idx + 1) % BS : m_rr;
        found = 0; win = 0;
        for (int k = 0; k < BS; k++) begin
          int j;
          j = (start + k) % BS;
          if (!found && m_valid[j] && (cyc >= m_acyc[j] + D) && bus.independent_instr[j] &&
              !(m_iv && j == m_idx)) begin
            found = 1; win = j;
          end
        end
        if (hs) begin
          m_valid[m_idx] = 0;
          m_rr = (m_idx + 1) % BS;
        end
        if (!m_iv || hs) begin
          m_iv = found;
          if (found) begin m_idx = win; m_instr = m_data[win]; end
        end
        if (do_alloc) begin
          m_valid[lo] = 1; m_data[lo] = bus.Instr_in; m_acyc[lo] = cyc + 1;
        end
        cyc++;
      end
    end
  end

  initial begin
    logic [0:BS-1] mv;
    int  lo;
    bit  full;
    forever begin
      @(negedge clk);
      full = 1; lo = 0;
      for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) begin full = 0; lo = i; end
      for (int i = 0; i < BS; i++) mv[i] = m_valid[i];
      check("cyc_in_ready", {31'b0, bus.in_ready}, {31'b0, !full});
      check("cyc_buffer_index", {28'b0, bus.buffer_index}, lo);
      check("cyc_alloc_fire", {31'b0, bus.alloc_fire}, {31'b0, bus.in_valid & !full});
      check("cyc_valid_entries", {16'b0, bus.valid_entries}, {16'b0, mv});
      check("cyc_issue_valid", {31'b0, bus.issue_valid}, {31'b0, m_iv});
      if (m_iv) begin
        check("cyc_issue_index", {28'b0, bus.issue_index}, m_idx);
        check("cyc_issue_instr", bus.issue_instr, m_instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.Instr_in = '0;
    bus.independent_instr = '0; bus.issue_ready = 1'b0;
    repeat (2) step();
    check("rst_issue_valid", {31'b0, bus.issue_valid}, 32'd0);
    check("rst_valid_entries", {16'b0, bus.valid_entries}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_buffer_index", {28'b0, bus.buffer_index}, 32'd0);
    rst = 1'b1;

    // Single allocation, three-edge issue latency, free on handshake
    bus.in_valid = 1'b1; bus.Instr_in = 32'h0050_0093;
    bus.independent_instr = 16'hFFFF; bus.issue_ready = 1'b1;
    #1;
    check("t1_buffer_index", {28'b0, bus.buffer_index}, 32'd0);
    check("t1_alloc_fire", {31'b0, bus.alloc_fire}, 32'd1);
    step(); bus.in_valid = 1'b0;
    check("t1_iv_e0", {31'b0, bus.issue_valid}, 32'd0);
    step(); check("t1_iv_e1", {31'b0, bus.issue_valid}, 32'd0);
    step(); check("t1_iv_e2", {31'b0, bus.issue_valid}, 32'd0);
    step();
    check("t1_iv_e3", {31'b0, bus.issue_valid}, 32'd1);
    check("t1_index", {28'b0, bus.issue_index}, 32'd0);
    check("t1_instr", bus.issue_instr, 32'h0050_0093);
    step();
    check("t1_freed", {16'b0, bus.valid_entries}, 32'd0);
    check("t1_iv_after", {31'b0, bus.issue_valid}, 32'd0);

    // Fill all slots, then drain in order one per cycle
    bus.issue_ready = 1'b0;
    for (int i = 0; i < BS; i++) begin
      bus.in_valid = 1'b1; bus.Instr_in = 32'h1000 + i;
      step();
    end
    bus.Instr_in = 32'h1FFF;
    #1;
    check("t2_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("t2_17th_alloc", {31'b0, bus.alloc_fire}, 32'd0);
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.issue_ready = 1'b1;
    for (int k = 0; k < BS; k++) begin
      check("t2_drain_valid", {31'b0, bus.issue_valid}, 32'd1);
      check("t2_drain_index", {28'b0, bus.issue_index}, k);
      check("t2_drain_instr", bus.issue_instr, 32'h1000 + k);
      step();
    end
    check("t2_empty_iv", {31'b0, bus.issue_valid}, 32'd0);
    bus.issue_ready = 1'b0;

    // Backpressure holds the presented entry stable
    bus.in_valid = 1'b1; bus.Instr_in = 32'hA0; step();
    bus.Instr_in = 32'hA1; step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", {31'b0, bus.issue_valid}, 32'd1);
      check("t3_hold_index", {28'b0, bus.issue_index}, 32'd0);
      check("t3_hold_instr", bus.issue_instr, 32'hA0);
      step();
    end
    bus.issue_ready = 1'b1;
    step();
    check("t3_freed_slot0", {16'b0, bus.valid_entries}, 32'h4000);
    check("t3_next_index", {28'b0, bus.issue_index}, 32'd1);
    step();
    bus.issue_ready = 1'b0;
    check("t3_done_iv", {31'b0, bus.issue_valid}, 32'd0);

    // Asynchronous reset during a pending handshake
    bus.in_valid = 1'b1; bus.Instr_in = 32'hB0; step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    check("t5_pre_iv", {31'b0, bus.issue_valid}, 32'd1);
    bus.issue_ready = 1'b1;
    #2; rst = 1'b0; #1;
    check("t5_async_iv", {31'b0, bus.issue_valid}, 32'd0);
    check("t5_async_valid", {16'b0, bus.valid_entries}, 32'd0);
    check("t5_async_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.issue_ready = 1'b0;
    step();
    rst = 1'b1;

    // Dependency gating: drain everything but slots 2 and 3, then 3 before 2
    bus.independent_instr = 16'hCFFF;
    for (int i = 0; i < BS; i++) begin
      bus.in_valid = 1'b1; bus.Instr_in = 32'h2000 + i;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.issue_ready = 1'b1;
    repeat (14) step();
    check("t4_blocked_iv", {31'b0, bus.issue_valid}, 32'd0);
    check("t4_left_slots", {16'b0, bus.valid_entries}, 32'h3000);
    bus.independent_instr = 16'h1000;
    step();
    check("t4_first_index", {28'b0, bus.issue_index}, 32'd3);
    check("t4_first_instr", bus.issue_instr, 32'h2003);
    bus.independent_instr = 16'h3000;
    step();
    check("t4_wrap_index", {28'b0, bus.issue_index}, 32'd2);
    check("t4_wrap_instr", bus.issue_instr, 32'h2002);
    step();
    check("t4_empty", {16'b0, bus.valid_entries}, 32'd0);
    bus.issue_ready = 1'b0;

    // Full buffer with slot 5 issuing: freed slot reusable only the next cycle
    bus.independent_instr = 16'h0400;
    for (int i = 0; i < BS; i++) begin
      bus.in_valid = 1'b1; bus.Instr_in = 32'h3000 + i;
      step();
    end
    bus.Instr_in = 32'h3FFF; bus.issue_ready = 1'b1;
    #1;
    check("t6_same_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("t6_same_alloc", {31'b0, bus.alloc_fire}, 32'd0);
    check("t6_issue_index", {28'b0, bus.issue_index}, 32'd5);
    check("t6_issue_instr", bus.issue_instr, 32'h3005);
    step();
    check("t6_next_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("t6_next_index", {28'b0, bus.buffer_index}, 32'd5);
    check("t6_next_alloc", {31'b0, bus.alloc_fire}, 32'd1);
    bus.issue_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("t6_refilled", {16'b0, bus.valid_entries}, 32'hFFFF);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
